issue_scoreboard: RTL and testbench

- Parametrised hazard scoreboard between the decode stage (control-unit outputs: rs1/rs2/rd, wen, scalar FU type) and multiple scalar functional units (arith, mult, div, lsu, csr).
- Tracks, for each architectural register, a pending-write bit and the FU tag of its producer, plus an outstanding-operation credit counter per FU.
- Decides each cycle whether the presented instruction may issue, reporting RAW, WAW and structural stall causes separately.
- Optional same-cycle writeback bypass, which the single-issue two-stage control path lacks.

---
 rtl/issue_scoreboard.sv | 155 +++++++++++++++
 tb/tb_issue_scoreboard.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard scoreboard: per-register pending/producer-tag tracking and
// per-FU credit counters, deciding each cycle whether decode may issue.
module issue_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int NUM_FU   = 5,
  parameter int FU_W     = 3,
  parameter int FU_DEPTH = 4,
  parameter int BYPASS   = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     flush,
  input  logic                     issue_valid,
  input  logic [REG_W-1:0]         issue_rs1,
  input  logic [REG_W-1:0]         issue_rs2,
  input  logic                     issue_use_rs1,
  input  logic                     issue_use_rs2,
  input  logic [REG_W-1:0]         issue_rd,
  input  logic                     issue_wen,
  input  logic [FU_W-1:0]          issue_fu,
  output logic                     issue_fire,
  output logic                     stall,
  output logic                     stall_raw,
  output logic                     stall_waw,
  output logic                     stall_struct,
  input  logic [NUM_FU-1:0]        done_valid,
  input  logic [NUM_FU-1:0]        done_wen,
  input  logic [NUM_FU*REG_W-1:0]  done_rd,
  output logic [NUM_REGS-1:0]      pending,
  output logic [7:0]               outstanding,
  output logic                     err
);

  localparam int CW  = 4;
  localparam bit BYP = (BYPASS != 0);

  logic [NUM_REGS-1:0] r_pending;
  logic [FU_W-1:0]     r_tag [NUM_REGS];
  logic [CW-1:0]       r_credit [NUM_FU];
  logic [7:0]          r_outstanding;
  logic                r_err;

  logic [NUM_REGS-1:0]   w_clr;
  logic [NUM_REGS-1:0]   w_set;
  logic [NUM_FU-1:0]     w_hit;
  logic                  w_err_done;
  logic [2**REG_W-1:0]   w_pend_ext;
  logic [2**REG_W-1:0]   w_clr_ext;
  logic                  w_raw1;
  logic                  w_raw2;
  logic                  w_full;
  logic                  w_fu_bad;
  logic [CW-1:0]         w_credit_nxt [NUM_FU];
  logic [7:0]            w_sum;
  logic                  w_err_credit;
  logic                  w_err_nxt;

  // A completion clears a register only if it is pending and was produced by that FU.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_clr      = '0;
    w_hit      = '0;
    w_err_done = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (done_valid[i] && done_wen[i] && done_rd[i*REG_W +: REG_W] != '0) begin
        for (int r = 1; r < NUM_REGS; r++) begin
          if (done_rd[i*REG_W +: REG_W] == REG_W'(r) && r_pending[r] &&
              r_tag[r] == FU_W'(i)) begin
            w_clr[r] = 1'b1;
            w_hit[i] = 1'b1;
          end
        end
        if (!w_hit[i] && !flush) w_err_done = 1'b1;
      end
    end
  end

  always_comb begin
    w_pend_ext                 = '0;
    w_pend_ext[NUM_REGS-1:0]   = r_pending;
    w_clr_ext                  = '0;
    w_clr_ext[NUM_REGS-1:0]    = w_clr;
  end

  always_comb begin
    w_raw1 = issue_use_rs1 && issue_rs1 != '0 && w_pend_ext[issue_rs1] &&
             !(BYP && w_clr_ext[issue_rs1]);
    w_raw2 = issue_use_rs2 && issue_rs2 != '0 && w_pend_ext[issue_rs2] &&
             !(BYP && w_clr_ext[issue_rs2]);
    w_fu_bad = {1'b0, issue_fu} >= (FU_W+1)'(NUM_FU);
    w_full   = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (issue_fu == FU_W'(i) && r_credit[i] == CW'(FU_DEPTH)) w_full = 1'b1;
    end
  end

  // WAW and structural checks deliberately ignore same-cycle completions.
  assign stall_raw    = issue_valid && (w_raw1 || w_raw2);
  assign stall_waw    = issue_valid && issue_wen && issue_rd != '0 && w_pend_ext[issue_rd];
  assign stall_struct = issue_valid && (w_full || w_fu_bad);
  assign issue_fire   = issue_valid && !stall_raw && !stall_waw && !stall_struct && !flush;
  assign stall        = issue_valid && !issue_fire;

  always_comb begin
    w_set = '0;
    if (issue_fire && issue_wen && issue_rd != '0) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue_rd == REG_W'(r)) w_set[r] = 1'b1;
      end
    end
  end

  // A completion on an empty FU is an error and must not underflow the credit.
  always_comb begin
    w_sum        = '0;
    w_err_credit = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (done_valid[i] && r_credit[i] == '0 && !flush) w_err_credit = 1'b1;
      if (flush)
        w_credit_nxt[i] = '0;
      else
        w_credit_nxt[i] = r_credit[i]
                        + CW'(issue_fire && issue_fu == FU_W'(i))
                        - CW'(done_valid[i] && r_credit[i] != '0);
      w_sum = w_sum + 8'(w_credit_nxt[i]);
    end
    w_err_nxt = r_err || w_err_done || w_err_credit || (issue_valid && w_fu_bad);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pending <= '0;
      // NOTE: the tag array is small flop storage, so it is reset like any other state.
      for (int r = 0; r < NUM_REGS; r++) r_tag[r] <= '0;
      for (int i = 0; i < NUM_FU; i++) r_credit[i] <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_pending <= flush ? '0 : ((r_pending & ~w_clr) | w_set);
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_set[r]) r_tag[r] <= issue_fu;
      end
      for (int i = 0; i < NUM_FU; i++) r_credit[i] <= w_credit_nxt[i];
      r_outstanding <= w_sum;
      r_err         <= w_err_nxt;
    end
  end

  assign pending     = r_pending;
  assign outstanding = r_outstanding;
  assign err         = r_err;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: a vector table for single-cycle behaviour
// plus hand sequences for bypass, credit limits, tag errors, flush and async reset.
module tb_issue_scoreboard;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        flush;
  logic        issue_valid, issue_use_rs1, issue_use_rs2, issue_wen;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic [2:0]  issue_fu;
  logic [4:0]  done_valid, done_wen;
  logic [24:0] done_rd;

  logic        fire_a, stall_a, raw_a, waw_a, str_a, err_a;
  logic [31:0] pend_a;
  logic [7:0]  out_a;
  logic        fire_b, stall_b, raw_b, waw_b, str_b, err_b;
  logic [31:0] pend_b;
  logic [7:0]  out_b;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  issue_scoreboard #(.BYPASS(1)) dut_a (
    .CLK(CLK), .RST(RST), .flush(flush), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_use_rs1(issue_use_rs1),
    .issue_use_rs2(issue_use_rs2), .issue_rd(issue_rd), .issue_wen(issue_wen),
    .issue_fu(issue_fu), .issue_fire(fire_a), .stall(stall_a), .stall_raw(raw_a),
    .stall_waw(waw_a), .stall_struct(str_a), .done_valid(done_valid),
    .done_wen(done_wen), .done_rd(done_rd), .pending(pend_a),
    .outstanding(out_a), .err(err_a));

  issue_scoreboard #(.BYPASS(0)) dut_b (
    .CLK(CLK), .RST(RST), .flush(flush), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_use_rs1(issue_use_rs1),
    .issue_use_rs2(issue_use_rs2), .issue_rd(issue_rd), .issue_wen(issue_wen),
    .issue_fu(issue_fu), .issue_fire(fire_b), .stall(stall_b), .stall_raw(raw_b),
    .stall_waw(waw_b), .stall_struct(str_b), .done_valid(done_valid),
    .done_wen(done_wen), .done_rd(done_rd), .pending(pend_b),
    .outstanding(out_b), .err(err_b));

  typedef struct packed {
    logic        v;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        w;
    logic [2:0]  fu;
    logic        dv;
    logic        dw;
    logic [2:0]  dfu;
    logic [4:0]  drd;
    logic        fl;
    logic        e_fire;
    logic        e_raw;
    logic        e_waw;
    logic        e_str;
    logic [31:0] e_pend;
    logic [7:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0; issue_valid = 1'b0; issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0;
    issue_wen = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0; issue_fu = '0;
    done_valid = '0; done_wen = '0; done_rd = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    #2;
    RST = 1'b0;
    idle();
  endtask

  task automatic issue(input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit w, input int fu);
    issue_valid = 1'b1;
    issue_rs1 = 5'(rs1); issue_use_rs1 = u1;
    issue_rs2 = 5'(rs2); issue_use_rs2 = u2;
    issue_rd = 5'(rd); issue_wen = w; issue_fu = 3'(fu);
  endtask

  task automatic done(input int fu, input bit w, input int rd);
    done_valid[fu] = 1'b1;
    done_wen[fu]   = w;
    done_rd[fu*5 +: 5] = 5'(rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // v rs1 u1 rs2 u2 rd w fu | dv dw dfu drd | fl | fire raw waw str | pend out err
    tbl[0] = '{1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5,  1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0,
               1'b1, 1'b0, 1'b0, 1'b0, 32'h20,  8'd1, 1'b0};
    tbl[1] = '{1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8,  1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0,
               1'b0, 1'b1, 1'b0, 1'b0, 32'h20,  8'd1, 1'b0};
    tbl[2] = '{1'b1, 5'd5, 1'b0, 5'd5, 1'b1, 5'd0,  1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0,
               1'b0, 1'b1, 1'b0, 1'b0, 32'h20,  8'd1, 1'b0};
    tbl[3] = '{1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd9,  1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0,
               1'b1, 1'b0, 1'b0, 1'b0, 32'h220, 8'd2, 1'b0};
    tbl[4] = '{1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9,  1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0,
               1'b0, 1'b0, 1'b1, 1'b0, 32'h220, 8'd2, 1'b0};
    tbl[5] = '{1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9,  1'b1, 3'd2, 1'b1, 1'b1, 3'd1, 5'd9, 1'b0,
               1'b0, 1'b0, 1'b1, 1'b0, 32'h20,  8'd1, 1'b0};
    tbl[6] = '{1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9,  1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0,
               1'b1, 1'b0, 1'b0, 1'b0, 32'h220, 8'd2, 1'b0};
    tbl[7] = '{1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0,  1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0,
               1'b1, 1'b0, 1'b0, 1'b0, 32'h220, 8'd3, 1'b0};
    tbl[8] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 3'd0, 1'b1, 1'b1, 3'd1, 5'd0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'h220, 8'd2, 1'b0};
    tbl[9] = '{1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 3'd5, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b1, 32'h220, 8'd2, 1'b1};

    idle();
    #12;
    RST = 1'b0;
    check("reset pending", pend_a, 32'h0);
    check("reset outstanding", 32'(out_a), 32'd0);
    check("reset err", 32'(err_a), 32'd0);
    check("reset fire", 32'(fire_a), 32'd0);
    check("reset stall", 32'({stall_a, raw_a, waw_a, str_a}), 32'd0);

    for (int k = 0; k < 10; k++) begin
      idle();
      issue_valid = tbl[k].v;
      issue_rs1 = tbl[k].rs1; issue_use_rs1 = tbl[k].u1;
      issue_rs2 = tbl[k].rs2; issue_use_rs2 = tbl[k].u2;
      issue_rd = tbl[k].rd; issue_wen = tbl[k].w; issue_fu = tbl[k].fu;
      flush = tbl[k].fl;
      if (tbl[k].dv) done(int'(tbl[k].dfu), tbl[k].dw, int'(tbl[k].drd));
      #1;
      check($sformatf("v%0d fire", k),   32'(fire_a), 32'(tbl[k].e_fire));
      check($sformatf("v%0d raw", k),    32'(raw_a),  32'(tbl[k].e_raw));
      check($sformatf("v%0d waw", k),    32'(waw_a),  32'(tbl[k].e_waw));
      check($sformatf("v%0d struct", k), 32'(str_a),  32'(tbl[k].e_str));
      tick();
      check($sformatf("v%0d pending", k),     pend_a,      tbl[k].e_pend);
      check($sformatf("v%0d outstanding", k), 32'(out_a),  32'(tbl[k].e_out));
      check($sformatf("v%0d err", k),         32'(err_a),  32'(tbl[k].e_err));
    end

    // Same-cycle writeback bypass: satisfies RAW only in the BYPASS=1 instance.
    do_reset();
    issue(0, 0, 0, 0, 5, 1, 0);
    tick();
    idle();
    issue(5, 1, 0, 0, 10, 1, 0);
    done(0, 1, 5);
    #1;
    check("byp fire a", 32'(fire_a), 32'd1);
    check("byp raw a", 32'(raw_a), 32'd0);
    check("nobyp raw b", 32'(raw_b), 32'd1);
    check("nobyp fire b", 32'(fire_b), 32'd0);
    tick();
    idle();
    check("byp pending a", pend_a, 32'h400);
    check("byp outstanding a", 32'(out_a), 32'd1);
    check("nobyp pending b", pend_b, 32'h0);
    check("nobyp outstanding b", 32'(out_b), 32'd0);

    // Credit limit on fu=1: a same-cycle done does not relieve the stall.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle();
      issue(0, 0, 0, 0, 6 + k, 1, 1);
      #1;
      check($sformatf("mult%0d fire", k), 32'(fire_a), 32'd1);
      tick();
    end
    idle();
    check("mult outstanding", 32'(out_a), 32'd4);
    issue(0, 0, 0, 0, 11, 1, 1);
    done(1, 0, 0);
    #1;
    check("mult5 struct", 32'(str_a), 32'd1);
    check("mult5 fire", 32'(fire_a), 32'd0);
    check("mult5 stall", 32'(stall_a), 32'd1);
    tick();
    idle();
    check("mult after done outstanding", 32'(out_a), 32'd3);
    issue(0, 0, 0, 0, 11, 1, 1);
    #1;
    check("mult5 retry fire", 32'(fire_a), 32'd1);
    tick();
    idle();
    check("mult pending", pend_a, 32'hBC0);
    check("mult outstanding full", 32'(out_a), 32'd4);
    check("mult err", 32'(err_a), 32'd0);

    // Completion whose FU does not match the recorded producer tag.
    do_reset();
    issue(0, 0, 0, 0, 7, 1, 2);
    tick();
    idle();
    issue(0, 0, 0, 0, 12, 1, 0);
    tick();
    idle();
    done(0, 1, 7);
    tick();
    idle();
    check("tag mismatch err", 32'(err_a), 32'd1);
    check("tag mismatch pending", pend_a, 32'h1080);
    check("tag mismatch outstanding", 32'(out_a), 32'd1);

    // Credit underflow, flush with pending writes, then async reset mid-operation.
    do_reset();
    done(3, 0, 0);
    tick();
    idle();
    check("underflow err", 32'(err_a), 32'd1);
    check("underflow outstanding", 32'(out_a), 32'd0);
    for (int k = 0; k < 3; k++) begin
      idle();
      issue(0, 0, 0, 0, 12 + k, 1, k);
      tick();
    end
    idle();
    check("pre-flush pending", pend_a, 32'h7000);
    check("pre-flush outstanding", 32'(out_a), 32'd3);
    flush = 1'b1;
    issue(0, 0, 0, 0, 15, 1, 0);
    done(0, 1, 12);
    #1;
    check("flush fire", 32'(fire_a), 32'd0);
    check("flush stall", 32'(stall_a), 32'd1);
    tick();
    idle();
    check("flush pending", pend_a, 32'h0);
    check("flush outstanding", 32'(out_a), 32'd0);
    check("flush err kept", 32'(err_a), 32'd1);
    issue(0, 0, 0, 0, 16, 1, 0);
    tick();
    idle();
    check("post-flush outstanding", 32'(out_a), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("async rst pending", pend_a, 32'h0);
    check("async rst outstanding", 32'(out_a), 32'd0);
    check("async rst err", 32'(err_a), 32'd0);
    RST = 1'b0;
    done(0, 1, 16);
    tick();
    idle();
    check("late done err", 32'(err_a), 32'd1);
    check("late done outstanding", 32'(out_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
